// File: rtl/cd_pkg.sv
// cd_pkg: shared definitions for the CSR receive-fetch engine.
//   - default CSR register addresses of the slave
//   - RX pending flag bit position and release word
//   - FSM state encoding
//   - byte lane selection helper (little-endian)
package cd_pkg;

  localparam logic [3:0]  CD_ADDR_INT_FLAG  = 4'd5;
  localparam logic [3:0]  CD_ADDR_RX_LEN    = 4'd6;
  localparam logic [3:0]  CD_ADDR_RX_CTRL   = 4'd7;
  localparam logic [3:0]  CD_ADDR_RX_PAGE   = 4'd8;
  localparam int          CD_RX_PENDING_BIT = 1;
  localparam logic [31:0] CD_RX_DONE_VAL    = 32'h0000_0001;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FLAG_RD = 4'd1,
    ST_FLAG_WT = 4'd2,
    ST_LEN_RD  = 4'd3,
    ST_LEN_WT  = 4'd4,
    ST_WORD_RD = 4'd5,
    ST_WORD_WT = 4'd6,
    ST_EMIT    = 4'd7,
    ST_DONE_WR = 4'd8
  } cd_state_e;

  // Little-endian lane select: index 0 is bits 7:0, index 3 is bits 31:24.
  function automatic logic [7:0] cd_byte_sel(input logic [31:0] word,
                                             input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cd_word_unpack.sv
// cd_word_unpack: turns 32-bit page words into a byte stream.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load_len, len     latch the frame byte count
//   load_word, word   latch a fresh page word and present its byte 0
//   m_data/m_valid/m_ready/m_last  byte stream handshake
//   remaining, index  bytes still owed and current lane (for the FSM)
//   xfer              a byte is transferred this cycle
module cd_word_unpack
  import cd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_len,
  input  logic [7:0]  len,
  input  logic        load_word,
  input  logic [31:0] word,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic [7:0]  remaining,
  output logic [1:0]  index,
  output logic        xfer
);

  logic [31:0] word_reg;

  assign xfer = m_valid && m_ready;

  // Word/lane/count registers and the registered byte-stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_reg  <= 32'd0;
      index     <= 2'd0;
      remaining <= 8'd0;
      m_data    <= 8'd0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else if (load_len) begin
      remaining <= len;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else if (load_word) begin
      word_reg <= word;
      index    <= 2'd0;
      m_data   <= cd_byte_sel(word, 2'd0);
      m_valid  <= (remaining != 8'd0);
      m_last   <= (remaining == 8'd1);
    end else if (xfer) begin
      // Count only while something is owed, so the counter never wraps.
      if (remaining != 8'd0) begin
        remaining <= remaining - 8'd1;
      end else begin
        remaining <= 8'd0;
      end
      index <= index + 2'd1;
      // Stream pauses when the frame ends or the word is used up; the
      // unused upper lanes of a short final word are simply dropped.
      if ((remaining == 8'd1) || (index == 2'd3)) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        m_data  <= cd_byte_sel(word_reg, index + 2'd1);
        m_valid <= 1'b1;
        m_last  <= (remaining == 8'd2);
      end
    end else begin
      m_valid <= m_valid;
    end
  end

endmodule

// File: rtl/cd_rx_fetch.sv
// cd_rx_fetch: polls a CSR slave on irq, reads the RX frame length and the
// auto-incrementing page window, streams the frame out byte by byte and
// releases the page with a done write.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable, irq       poll permission and slave interrupt
//   csr_*             CSR master (read data valid one cycle after csr_read)
//   m_data/m_valid/m_ready/m_last  byte stream
//   busy              high whenever the FSM is not in IDLE
module cd_rx_fetch
  import cd_pkg::*;
#(
  parameter logic [3:0]  ADDR_INT_FLAG  = CD_ADDR_INT_FLAG,
  parameter logic [3:0]  ADDR_RX_LEN    = CD_ADDR_RX_LEN,
  parameter logic [3:0]  ADDR_RX_CTRL   = CD_ADDR_RX_CTRL,
  parameter logic [3:0]  ADDR_RX_PAGE   = CD_ADDR_RX_PAGE,
  parameter int          RX_PENDING_BIT = CD_RX_PENDING_BIT,
  parameter logic [31:0] RX_DONE_VAL    = CD_RX_DONE_VAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        irq,
  output logic [3:0]  csr_address,
  output logic        csr_read,
  input  logic [31:0] csr_readdata,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy
);

  cd_state_e   state;
  logic        load_len;
  logic        load_word;
  logic [7:0]  remaining;
  logic [1:0]  index;
  logic        xfer;

  // The slave returns data in the *_WT states, so latch there.
  assign load_len  = (state == ST_LEN_WT);
  assign load_word = (state == ST_WORD_WT);

  cd_word_unpack u_unpack (
    .clk       (clk),
    .reset     (reset),
    .load_len  (load_len),
    .len       (csr_readdata[7:0]),
    .load_word (load_word),
    .word      (csr_readdata),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .remaining (remaining),
    .index     (index),
    .xfer      (xfer)
  );

  // Control FSM; strobes are raised on entry to the *_RD / DONE_WR states
  // so they are high for exactly the one cycle spent in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      csr_read      <= 1'b0;
      csr_write     <= 1'b0;
      csr_address   <= 4'd0;
      csr_writedata <= 32'd0;
      busy          <= 1'b0;
    end else begin
      csr_read  <= 1'b0;
      csr_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && irq) begin
            state       <= ST_FLAG_RD;
            csr_read    <= 1'b1;
            csr_address <= ADDR_INT_FLAG;
            busy        <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_FLAG_RD: state <= ST_FLAG_WT;
        ST_FLAG_WT: begin
          if (csr_readdata[RX_PENDING_BIT]) begin
            state       <= ST_LEN_RD;
            csr_read    <= 1'b1;
            csr_address <= ADDR_RX_LEN;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_LEN_RD: state <= ST_LEN_WT;
        ST_LEN_WT: begin
          if (csr_readdata[7:0] == 8'd0) begin
            state         <= ST_DONE_WR;
            csr_write     <= 1'b1;
            csr_address   <= ADDR_RX_CTRL;
            csr_writedata <= RX_DONE_VAL;
          end else begin
            state       <= ST_WORD_RD;
            csr_read    <= 1'b1;
            csr_address <= ADDR_RX_PAGE;
          end
        end
        ST_WORD_RD: state <= ST_WORD_WT;
        ST_WORD_WT: state <= ST_EMIT;
        ST_EMIT: begin
          if (xfer && (remaining == 8'd1)) begin
            state         <= ST_DONE_WR;
            csr_write     <= 1'b1;
            csr_address   <= ADDR_RX_CTRL;
            csr_writedata <= RX_DONE_VAL;
          end else if (xfer && (index == 2'd3)) begin
            state       <= ST_WORD_RD;
            csr_read    <= 1'b1;
            csr_address <= ADDR_RX_PAGE;
          end else begin
            state <= ST_EMIT;
          end
        end
        ST_DONE_WR: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cd_rx_fetch.sv
// Directed bench for cd_rx_fetch with a behavioural CSR slave.
module tb_cd_rx_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        irq;
  logic [3:0]  csr_address;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [7:0]  m_data;
  logic        m_valid;
  wire         m_ready;
  logic        m_last;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // slave state
  logic [31:0] flag_val;
  logic [31:0] len_val;
  logic [31:0] page_mem [0:63];
  int          page_ptr = 0;
  logic        ptr_clr;
  int          rd_total = 0, rd_flag = 0, rd_len = 0, rd_page = 0;
  int          wr_total = 0, collide = 0;
  logic [3:0]  wr_addr = 4'd0;
  logic [31:0] wr_data = 32'd0;

  // stream capture
  logic [7:0]  cap_data [$];
  logic        cap_last [$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'd0;
  int          stall_bad = 0;

  logic        tog_en;
  logic        phase = 1'b0;
  assign m_ready = tog_en ? phase : 1'b1;

  always #5 clk = ~clk;

  cd_rx_fetch dut (
    .clk(clk), .reset(reset), .enable(enable), .irq(irq),
    .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy)
  );

  always @(posedge clk) phase <= ~phase;

  // CSR slave: registered read data, auto-incrementing page window.
  always @(posedge clk) begin
    if (ptr_clr) page_ptr <= 0;
    if (csr_read) begin
      rd_total <= rd_total + 1;
      case (csr_address)
        4'd5: begin csr_readdata <= flag_val; rd_flag <= rd_flag + 1; end
        4'd6: begin csr_readdata <= len_val;  rd_len  <= rd_len + 1;  end
        4'd8: begin
          csr_readdata <= page_mem[page_ptr[5:0]];
          page_ptr     <= page_ptr + 1;
          rd_page      <= rd_page + 1;
        end
        default: csr_readdata <= 32'hDEAD_BEEF;
      endcase
    end
    if (csr_write) begin
      wr_total <= wr_total + 1;
      wr_addr  <= csr_address;
      wr_data  <= csr_writedata;
    end
    if (csr_read && csr_write) collide <= collide + 1;
  end

  // Byte capture and stall-stability monitor.
  always @(posedge clk) begin
    if (!reset && m_valid && m_ready) begin
      cap_data.push_back(m_data);
      cap_last.push_back(m_last);
    end
    if (!reset && prev_stall && m_valid && (m_data !== prev_data))
      stall_bad <= stall_bad + 1;
    prev_stall <= !reset && m_valid && !m_ready;
    prev_data  <= m_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic [31:0] flag, input logic [31:0] len);
    flag_val = flag;
    len_val  = len;
    ptr_clr  = 1'b1;
    @(posedge clk); #1;
    ptr_clr  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int budget);
    int n;
    irq = 1'b1;
    @(posedge clk); #1;
    irq = 1'b0;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int base, r0, p0, w0, lastn;
    reset = 1'b1; enable = 1'b1; irq = 1'b0; tog_en = 1'b0; ptr_clr = 1'b0;
    flag_val = 32'd0; len_val = 32'd0;
    for (int i = 0; i < 64; i++) page_mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read",  {31'd0, csr_read},  32'd0);
    chk("rst_write", {31'd0, csr_write}, 32'd0);
    chk("rst_valid", {31'd0, m_valid},   32'd0);
    chk("rst_last",  {31'd0, m_last},    32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_addr",  {28'd0, csr_address}, 32'd0);
    chk("rst_wdata", csr_writedata,      32'd0);
    chk("rst_mdata", {24'd0, m_data},    32'd0);
    reset = 1'b0;

    // no pending frame: one flag read only
    setup(32'd0, 32'd0);
    r0 = rd_total; w0 = wr_total;
    run_frame("nopend", 50);
    chk("nopend_reads",  rd_total - r0, 32'd1);
    chk("nopend_writes", wr_total - w0, 32'd0);
    chk("nopend_flag",   rd_flag, 32'd1);

    // LEN=5 frame
    setup(32'd2, 32'd5);
    page_mem[0] = 32'h4433_2211; page_mem[1] = 32'h0000_00AA;
    base = cap_data.size(); p0 = rd_page; w0 = wr_total;
    run_frame("len5", 200);
    chk("len5_count", cap_data.size() - base, 32'd5);
    if (cap_data.size() - base == 5) begin
      logic [7:0] exp5 [5];
      exp5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("len5_byte%0d", i), {24'd0, cap_data[base+i]}, {24'd0, exp5[i]});
        chk($sformatf("len5_last%0d", i), {31'd0, cap_last[base+i]}, (i == 4) ? 32'd1 : 32'd0);
      end
    end
    chk("len5_pages",  rd_page - p0, 32'd2);
    chk("len5_writes", wr_total - w0, 32'd1);
    chk("len5_waddr",  {28'd0, wr_addr}, 32'd7);
    chk("len5_wdata",  wr_data, 32'd1);

    // LEN=0 frame
    setup(32'd2, 32'd0);
    base = cap_data.size(); p0 = rd_page; w0 = wr_total;
    run_frame("len0", 50);
    chk("len0_pages",  rd_page - p0, 32'd0);
    chk("len0_bytes",  cap_data.size() - base, 32'd0);
    chk("len0_writes", wr_total - w0, 32'd1);

    // LEN=8 with a toggling m_ready
    setup(32'd2, 32'd8);
    page_mem[0] = 32'h0403_0201; page_mem[1] = 32'h0807_0605;
    base = cap_data.size(); p0 = rd_page; w0 = wr_total;
    tog_en = 1'b1;
    run_frame("len8", 300);
    tog_en = 1'b0;
    chk("len8_count", cap_data.size() - base, 32'd8);
    if (cap_data.size() - base == 8)
      for (int i = 0; i < 8; i++)
        chk($sformatf("len8_byte%0d", i), {24'd0, cap_data[base+i]}, i + 1);
    chk("len8_stable", stall_bad, 32'd0);
    chk("len8_pages",  rd_page - p0, 32'd2);
    chk("len8_writes", wr_total - w0, 32'd1);

    // reset on the 3rd byte of a LEN=6 frame, then refetch
    setup(32'd2, 32'd6);
    page_mem[0] = 32'hD4C3_B2A1; page_mem[1] = 32'h0000_F6E5;
    base = cap_data.size(); w0 = wr_total;
    irq = 1'b1;
    @(posedge clk); #1;
    irq = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (m_valid && (cap_data.size() - base == 2)) break;
      @(posedge clk); #1;
    end
    chk("mid_third", {31'd0, m_valid}, 32'd1);
    chk("mid_data3", {24'd0, m_data}, 32'hC3);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_valid", {31'd0, m_valid},   32'd0);
    chk("mid_busy",  {31'd0, busy},      32'd0);
    chk("mid_read",  {31'd0, csr_read},  32'd0);
    chk("mid_mdata", {24'd0, m_data},    32'd0);
    chk("mid_last",  {31'd0, m_last},    32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_nodone", wr_total - w0, 32'd0);
    setup(32'd2, 32'd6);
    base = cap_data.size();
    run_frame("refetch", 200);
    chk("refetch_count", cap_data.size() - base, 32'd6);
    if (cap_data.size() - base == 6) begin
      logic [7:0] exp6 [6];
      exp6 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
      for (int i = 0; i < 6; i++)
        chk($sformatf("refetch_byte%0d", i), {24'd0, cap_data[base+i]}, {24'd0, exp6[i]});
    end
    chk("refetch_writes", wr_total - w0, 32'd1);

    // LEN=255
    setup(32'd2, 32'd255);
    for (int w = 0; w < 64; w++)
      page_mem[w] = {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
    base = cap_data.size(); p0 = rd_page; w0 = wr_total;
    run_frame("len255", 3000);
    chk("len255_pages", rd_page - p0, 32'd64);
    chk("len255_count", cap_data.size() - base, 32'd255);
    if (cap_data.size() - base == 255) begin
      int bad;
      bad = 0; lastn = 0;
      for (int k = 0; k < 255; k++) begin
        if (cap_data[base+k] !== 8'(k + 1)) bad++;
        if (cap_last[base+k]) lastn++;
      end
      chk("len255_bytes", bad, 32'd0);
      chk("len255_lastcnt", lastn, 32'd1);
      chk("len255_last", {31'd0, cap_last[base+254]}, 32'd1);
    end
    chk("len255_writes", wr_total - w0, 32'd1);

    chk("no_collision", collide, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cd_rx_fetch.md
CD_RX_FETCH -- requirements
Module: cd_rx_fetch

Interface
REQ-001 Parameter ADDR_INT_FLAG, default 4'd5, CSR address of the interrupt/status flag register.
REQ-002 Parameter ADDR_RX_LEN, default 4'd6, CSR address of the received-frame length register; bits 7:0 hold the byte count.
REQ-003 Parameter ADDR_RX_CTRL, default 4'd7, CSR address of the RX control register.
REQ-004 Parameter ADDR_RX_PAGE, default 4'd8, CSR address of the RX page window; each read auto-increments inside the slave.
REQ-005 Parameter RX_PENDING_BIT, default 1, INT_FLAG bit meaning an unread frame is present.
REQ-006 Parameter RX_DONE_VAL, default 32'h0000_0001, word written to RX_CTRL to release the page.
REQ-007 clk  in  1  sole clock; all logic on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 enable  in  1  when high, fetching is permitted.
REQ-010 irq  in  1  interrupt line from the CSR slave.
REQ-011 csr_address  out  4  CSR address.
REQ-012 csr_read  out  1  one-cycle read strobe.
REQ-013 csr_readdata  in  32  read data.
REQ-014 csr_write  out  1  one-cycle write strobe.
REQ-015 csr_writedata  out  32  write data.
REQ-016 m_data  out  8  frame byte.
REQ-017 m_valid  out  1  m_data is valid.
REQ-018 m_ready  in  1  downstream accepts the byte.
REQ-019 m_last  out  1  marks the final byte of a frame.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 Read data SHALL be sampled exactly one cycle after the csr_read strobe; csr_read and csr_write SHALL never be high together.
REQ-022 The FSM SHALL use the states IDLE, FLAG_RD, FLAG_WT, LEN_RD, LEN_WT, WORD_RD, WORD_WT, EMIT and DONE_WR.
REQ-023 IDLE SHALL move to FLAG_RD when enable=1 and irq=1.
REQ-024 FLAG_WT SHALL move to LEN_RD if bit RX_PENDING_BIT=1, and to IDLE otherwise.
REQ-025 LEN_WT SHALL latch remaining := csr_readdata[7:0]; if that value is 0 the FSM SHALL go to DONE_WR, otherwise to WORD_RD.
REQ-026 WORD_WT SHALL latch the 32-bit word and a 2-bit byte index of 0, then move to EMIT.
REQ-027 Bytes SHALL be emitted little-endian: index 0 is bits 7:0 and index 3 is bits 31:24.
REQ-028 In EMIT, m_valid SHALL be high and m_data SHALL be stable until m_ready; a transfer is m_valid&&m_ready.
REQ-029 Each transfer SHALL decrement remaining and increment the index.
REQ-030 After a transfer, if remaining becomes 0 the FSM SHALL go to DONE_WR; if the index wraps to 0 it SHALL go to WORD_RD; otherwise it SHALL stay in EMIT.
REQ-031 m_last SHALL be high only in EMIT while remaining=1.
REQ-032 DONE_WR SHALL issue one write of RX_DONE_VAL to ADDR_RX_CTRL and then return to IDLE.
REQ-033 Lengths that are not a multiple of 4 SHALL read ceil(len/4) words and discard the unused upper bytes.
REQ-034 A length of 255 SHALL produce 64 word reads and 255 transfers.
REQ-035 enable=0 SHALL only block the IDLE->FLAG_RD transition; an in-progress frame SHALL complete.
REQ-036 When irq is still high on return to IDLE, the next poll SHALL start on the following cycle.
REQ-037 remaining SHALL be 8 bits and SHALL never underflow.

Reset
REQ-038 While reset=1 the FSM SHALL go to IDLE; csr_read, csr_write, m_valid, m_last and busy SHALL be 0; csr_address, csr_writedata and m_data SHALL be 0; remaining and the index SHALL be 0.
REQ-039 Reset asserted mid-frame SHALL abandon the frame with no done write; the first frame after reset SHALL be fetched again.

Structure
REQ-040 The CSR address defaults, the RX_PENDING_BIT default, RX_DONE_VAL and the state encoding SHALL live in a shared cd_pkg package.
REQ-041 The byte unpacker (word register, index, remaining counter, m_* outputs) SHALL be a single sub-module, cd_word_unpack.

Verification
REQ-042 irq=1, INT_FLAG=0 -> exactly one read of address 5, no further CSR access, back to IDLE.
REQ-043 INT_FLAG=2, LEN=5, words 0x44332211 and 0x000000AA, m_ready=1 -> bytes 11,22,33,44,AA, m_last on AA, one write of 1 to address 7.
REQ-044 LEN=0 -> no page reads, no m_valid, one done write.
REQ-045 LEN=8 with m_ready toggling 1,0 -> 8 bytes in order, m_data stable while stalled, 2 page reads.
REQ-046 Reset asserted on the 3rd byte of a LEN=6 frame -> outputs 0 next cycle, no done write, same frame fetched from byte 0 on the next irq.
REQ-047 LEN=255 -> 64 page reads, 255 bytes, m_last only on the 255th byte.
